// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared constants and types for the register-file read arbiter
package rf_arb_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;

  // Largest supported requester count; the id type covers any NUM_REQ up to this.
  localparam int MAX_REQ  = 8;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef logic [$clog2(MAX_REQ)-1:0] id_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker starting after last_grant
module rr_priority_picker
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  id_t                i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output id_t                o_idx
);

  logic w_found;

  // Search indices above last_grant first, then wrap around to 0..last_grant.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && (j > int'(i_last_grant)) && i_req[j]) begin
        w_found    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = id_t'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && (j <= int'(i_last_grant)) && i_req[j]) begin
        w_found    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = id_t'(j);
      end
    end
  end

endmodule

// File: rtl/rf_read_arbiter.sv
// rtl/rf_read_arbiter.sv - round-robin arbiter with lock for a shared register-file read port
module rf_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = rf_arb_pkg::DATA_W,
  parameter int ADDR_W  = rf_arb_pkg::ADDR_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]             req_lock,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ADDR_W-1:0]              rf_sel,
  input  logic [DATA_W-1:0]              rf_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_data
);

  import rf_arb_pkg::id_t;
  import rf_arb_pkg::arb_state_e;
  import rf_arb_pkg::ARB;
  import rf_arb_pkg::LOCKED;
  import rf_arb_pkg::ZERO_REG;

  arb_state_e          r_state;
  id_t                 r_last_grant;
  logic [ADDR_W-1:0]   r_rf_sel;
  logic [NUM_REQ-1:0]  r_pipe_oh;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;

  logic [NUM_REQ-1:0]  w_pick_oh;
  id_t                 w_pick_idx;
  logic [NUM_REQ-1:0]  w_owner_oh;
  logic [NUM_REQ-1:0]  w_ready;
  logic                w_hs;
  logic                w_hs_lock;
  id_t                 w_hs_idx;
  logic [ADDR_W-1:0]   w_hs_addr;

  rr_priority_picker #(
    .NUM_REQ      (NUM_REQ)
  ) u_picker (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick_oh),
    .o_idx        (w_pick_idx)
  );

  // While locked the owner is always the last grantee, so last_grant doubles as the lock id.
  always_comb begin
    w_owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_owner_oh[i] = (id_t'(i) == r_last_grant);
    end
  end

  // Grant: owner only while locked, round-robin pick otherwise; nothing while in reset.
  always_comb begin
    w_ready = '0;
    if (!reset) begin
      if (r_state == LOCKED) begin
        w_ready = req_valid & w_owner_oh;
      end else begin
        w_ready = w_pick_oh;
      end
    end
  end

  // Handshake decode: ready only asserts with valid, so any ready bit is a transfer.
  always_comb begin
    w_hs      = |w_ready;
    w_hs_lock = |(w_ready & req_lock);
    w_hs_idx  = (r_state == LOCKED) ? r_last_grant : w_pick_idx;
    w_hs_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_ready[i]) begin
        w_hs_addr = req_addr[i];
      end
    end
  end

  // FSM: a locked handshake holds the port; anything else (incl. owner dropping valid) releases it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ARB;
    end else if (w_hs && w_hs_lock) begin
      r_state <= LOCKED;
    end else begin
      r_state <= ARB;
    end
  end

  // Grant bookkeeping and the registered mux select, which holds when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= id_t'(NUM_REQ - 1);
      r_rf_sel     <= '0;
    end else if (w_hs) begin
      r_last_grant <= w_hs_idx;
      r_rf_sel     <= w_hs_addr;
    end
  end

  // Response pipe: the grant vector rides one cycle alongside the select, then strobes out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe_oh   <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_pipe_oh   <= w_ready;
      r_rsp_valid <= r_pipe_oh;
      if (|r_pipe_oh) begin
        r_rsp_data <= (r_rf_sel == ADDR_W'(ZERO_REG)) ? '0 : rf_data;
      end
    end
  end

  assign req_ready = w_ready;
  assign rf_sel    = r_rf_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// tb/tb_rf_read_arbiter.sv - randomized self-checking bench for rf_read_arbiter
module tb_rf_read_arbiter;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [N-1:0]       req_valid = '0;
  logic [N-1:0][4:0]  req_addr = '0;
  logic [N-1:0]       req_lock = '0;
  logic [N-1:0]       req_ready;
  logic [4:0]         rf_sel;
  logic [63:0]        rf_data;
  logic [N-1:0]       rsp_valid;
  logic [63:0]        rsp_data;

  logic [63:0]        mem [32];

  assign rf_data = mem[rf_sel];

  always #5 clk = ~clk;

  rf_read_arbiter #(.NUM_REQ(N), .DATA_W(64), .ADDR_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .rf_sel    (rf_sel),
    .rf_data   (rf_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: owner of the port (-1 = free), last grantee, expected select,
  // and a two-slot response pipeline of (requester, address).
  int          m_owner;
  int          m_last;
  logic [4:0]  m_sel;
  int          st1_id;
  logic [4:0]  st1_addr;
  int          rsp_id;
  logic [63:0] rsp_dat;
  int          last_g;

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_sel   = '0;
    st1_id  = -1;
    st1_addr = '0;
    rsp_id  = -1;
    rsp_dat = '0;
    last_g  = -1;
  endtask

  function automatic int model_grant();
    int k;
    if (m_owner >= 0) return req_valid[m_owner] ? m_owner : -1;
    for (int i = 1; i <= N; i++) begin
      k = (m_last + i) % N;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic step_chk(input bit use_dir, input logic [N-1:0] dir_ready);
    int g;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    @(negedge clk);
    g = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    if (use_dir) check_eq("dir_ready", 64'(req_ready), 64'(dir_ready));
    check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
    check_eq("rf_sel", 64'(rf_sel), 64'(m_sel));
    exp_rv = '0;
    if (rsp_id >= 0) exp_rv[rsp_id] = 1'b1;
    check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (rsp_id >= 0) check_eq("rsp_data", rsp_data, rsp_dat);
    @(posedge clk);
    rsp_id = st1_id;
    if (st1_id >= 0) rsp_dat = (st1_addr == 5'd31) ? 64'd0 : mem[st1_addr];
    st1_id = g;
    if (g >= 0) begin
      st1_addr = req_addr[g];
      m_last   = g;
      m_sel    = req_addr[g];
      m_owner  = req_lock[g] ? g : -1;
    end else begin
      m_owner  = -1;
    end
    last_g = g;
    #1;
  endtask

  task automatic step();
    step_chk(1'b0, '0);
  endtask

  task automatic drain();
    req_valid = '0;
    req_lock  = '0;
    repeat (3) step();
  endtask

  // Reset is asserted away from the clock edge and checked asynchronously; requests stay
  // raised during reset to confirm nothing is granted.
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    model_reset();
    req_valid = '1;
    req_lock  = '0;
    #1;
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_rf_sel", 64'(rf_sel), 64'd0);
    check_eq("rst_rsp_data", rsp_data, 64'd0);
    repeat (cycles) begin
      @(negedge clk);
      check_eq("rst_hold_rsp_valid", 64'(rsp_valid), 64'd0);
      check_eq("rst_hold_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    logic [N-1:0] e;
    for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
    mem[5]  = 64'h0000_0000_DEAD_BEEF;
    mem[31] = 64'hFFFF_FFFF_FFFF_FFFF;
    model_reset();

    do_reset(3);

    // Contention from reset: strict rotation 0,1,2,3,0,1,2,3.
    req_valid = '1;
    for (int k = 0; k < N; k++) req_addr[k] = 5'(k + 1);
    for (int i = 0; i < 8; i++) begin
      e = '0;
      e[i % N] = 1'b1;
      step_chk(1'b1, e);
    end
    drain();

    // Single request with known data.
    req_valid = 4'b0100;
    req_addr[2] = 5'd5;
    step_chk(1'b1, 4'b0100);
    req_valid = '0;
    step();
    check_eq("single_rsp_valid", 64'(rsp_valid), 64'b0100);
    check_eq("single_rsp_data", rsp_data, 64'hDEAD_BEEF);
    drain();

    // Zero register reads as zero whatever the mux returns.
    req_valid = 4'b0010;
    req_addr[1] = 5'd31;
    step_chk(1'b1, 4'b0010);
    req_valid = '0;
    step();
    check_eq("zero_rsp_valid", 64'(rsp_valid), 64'b0010);
    check_eq("zero_rsp_data", rsp_data, 64'd0);
    drain();

    // Lock: req 3 holds the port for several transfers while req 0 waits.
    req_valid = 4'b1001;
    req_lock  = 4'b1000;
    req_addr[3] = 5'd7;
    req_addr[0] = 5'd2;
    repeat (3) step_chk(1'b1, 4'b1000);
    req_lock = 4'b0000;
    step_chk(1'b1, 4'b1000);
    req_valid = 4'b0001;
    step_chk(1'b1, 4'b0001);
    drain();

    // Lock abandon: owner drops valid, next cycle the waiting requester wins.
    req_valid = 4'b0110;
    req_lock  = 4'b0010;
    req_addr[1] = 5'd3;
    req_addr[2] = 5'd4;
    step_chk(1'b1, 4'b0010);
    req_valid = 4'b0100;
    req_lock  = 4'b0000;
    step_chk(1'b1, 4'b0000);
    step_chk(1'b1, 4'b0100);
    drain();

    // Reset one cycle after a handshake discards the response.
    req_valid = 4'b0001;
    req_addr[0] = 5'd9;
    step_chk(1'b1, 4'b0001);
    do_reset(2);
    step_chk(1'b1, 4'b0001);
    drain();

    // Random traffic: waiting requesters hold; granted or idle ones pick afresh.
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      for (int k = 0; k < N; k++) begin
        if (k == last_g || !req_valid[k]) begin
          req_valid[k] = ($urandom % 3) != 0;
          req_addr[k]  = 5'($urandom);
          req_lock[k]  = ($urandom % 4) == 0;
        end
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
